// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: bus-cycle engine for the RTC multiplexed address/data bus.
// Runs one register transfer per request as two phases, address then data.
// Each phase has three parts: setup, strobe and hold.
// When the transfer is finished it pulses fin for one cycle.
// Every output is registered. Output values are decoded from the next state,
// so each bus phase appears on the pins in the same cycle the state is entered.
module rtc_bus_ctrl #(
  parameter int T_FASE = 4,
  parameter int CW     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       escritura,
  input  logic       lectura,
  input  logic [7:0] dir,
  input  logic [7:0] dato,
  input  logic [7:0] ad_in,
  output logic       fin,
  output logic       ocupado,
  output logic [7:0] dato_leido,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel,
  output logic [7:0] ad_out,
  output logic       ad_oe
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_HOLD,
    DATA_SETUP,
    DATA_STROBE,
    DATA_HOLD,
    DONE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] fase_cnt;
  logic          fase_fin;
  logic          req;

  logic [7:0]    dir_q;
  logic [7:0]    dato_q;
  logic          es_escritura;

  // In IDLE the values still come straight from the request inputs.
  // This lets the first address-phase cycle already drive the new address.
  logic [7:0]    dir_sel;
  logic [7:0]    dato_sel;
  logic          esc_sel;

  logic          cs_n_d;
  logic          rd_n_d;
  logic          wr_n_d;
  logic          ad_sel_d;
  logic          ad_oe_d;
  logic [7:0]    ad_out_d;
  logic          fin_d;
  logic          ocupado_d;

  assign fase_fin = (fase_cnt == CW'(T_FASE - 1));
  assign req      = escritura | lectura;
  assign dir_sel  = (state == IDLE) ? dir       : dir_q;
  assign dato_sel = (state == IDLE) ? dato      : dato_q;
  assign esc_sel  = (state == IDLE) ? escritura : es_escritura;

  // State register and phase counter.
  // The counter restarts on every state change and rests at zero in IDLE and DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fase_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state || state == IDLE || state == DONE) begin
        fase_cnt <= '0;
      end else begin
        fase_cnt <= fase_cnt + 1'b1;
      end
    end
  end

  // Next-state logic.
  // Each bus state is held until its phase time runs out.
  // A write request wins over a simultaneous read request.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:        if (req)      next_state = ADDR_SETUP;
      ADDR_SETUP:  if (fase_fin) next_state = ADDR_STROBE;
      ADDR_STROBE: if (fase_fin) next_state = ADDR_HOLD;
      ADDR_HOLD:   if (fase_fin) next_state = DATA_SETUP;
      DATA_SETUP:  if (fase_fin) next_state = DATA_STROBE;
      DATA_STROBE: if (fase_fin) next_state = DATA_HOLD;
      DATA_HOLD:   if (fase_fin) next_state = DONE;
      DONE:                      next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  // Latch address, data and operation type when a request is accepted.
  // This frees upstream to change dir and dato immediately afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q        <= '0;
      dato_q       <= '0;
      es_escritura <= 1'b0;
    end else if (state == IDLE && req) begin
      dir_q        <= dir;
      dato_q       <= dato;
      es_escritura <= escritura;
    end
  end

  // Output decode from the state being entered; unlisted signals keep idle values.
  always_comb begin
    cs_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    ad_sel_d  = 1'b1;
    ad_oe_d   = 1'b0;
    ad_out_d  = 8'h00;
    fin_d     = 1'b0;
    ocupado_d = (next_state != IDLE);
    unique case (next_state)
      ADDR_SETUP, ADDR_HOLD: begin
        ad_sel_d = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = dir_sel;
      end
      ADDR_STROBE: begin
        ad_sel_d = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = dir_sel;
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
      end
      DATA_SETUP, DATA_HOLD: begin
        if (esc_sel) begin
          ad_oe_d  = 1'b1;
          ad_out_d = dato_sel;
        end
      end
      DATA_STROBE: begin
        cs_n_d = 1'b0;
        if (esc_sel) begin
          wr_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = dato_sel;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      DONE:    fin_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers; reset forces every bus signal back to its idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      ad_sel  <= 1'b1;
      ad_oe   <= 1'b0;
      ad_out  <= 8'h00;
      fin     <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      cs_n    <= cs_n_d;
      rd_n    <= rd_n_d;
      wr_n    <= wr_n_d;
      ad_sel  <= ad_sel_d;
      ad_oe   <= ad_oe_d;
      ad_out  <= ad_out_d;
      fin     <= fin_d;
      ocupado <= ocupado_d;
    end
  end

  // Capture read data on the edge that ends the read strobe.
  // The captured value is kept until the next read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      dato_leido <= 8'h00;
    end else if (state == DATA_STROBE && fase_fin && !es_escritura) begin
      dato_leido <= ad_in;
    end
  end

endmodule
